// File: rtl/hilo_div_seq_if.sv
// Pipeline <-> divide/HI-LO bundle: requests and MTHI/MTLO writes in, HI/LO and stall status out.
// master = execute stage side, slave = the divide sequencer.
interface hilo_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor, mthi_we, mtlo_we, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, mthi_we, mtlo_we, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/hilo_div_seq.sv
// Restoring DIV/DIVU sequencer owning HI/LO: WIDTH+1 cycles busy (1 for divide-by-zero), done pulses after.
// No queueing: start and MTHI/MTLO are ignored while busy; start beats a same-cycle MT write.
module hilo_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    hilo_div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] work;     // {partial remainder, dividend bits / quotient bits}
    logic [WIDTH-1:0]   dvsr;
    logic [CW-1:0]      count;
    logic               q_neg;
    logic               r_neg;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [2*WIDTH-1:0] work_next;

    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        if (bus.is_signed && bus.dividend[WIDTH-1]) a_mag = -bus.dividend;
        if (bus.is_signed && bus.divisor[WIDTH-1])  b_mag = -bus.divisor;

        // The shifted remainder can need WIDTH+1 bits, so compare with one extra bit.
        shifted   = {work, 1'b0};
        trial     = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr};
        fits      = ~trial[WIDTH];
        work_next = {(fits ? trial[WIDTH-1:0] : shifted[2*WIDTH-1:WIDTH]),
                     work[WIDTH-2:0], fits};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            dvsr   <= '0;
            count  <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        count  <= '0;
                        if (bus.divisor == '0) begin
                            // Quotient all ones, remainder is the raw dividend, no sign fix-up.
                            dz_q  <= 1'b1;
                            work  <= {bus.dividend, {WIDTH{1'b1}}};
                            dvsr  <= '0;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= FIX;
                        end else begin
                            dz_q  <= 1'b0;
                            work  <= {{WIDTH{1'b0}}, a_mag};
                            dvsr  <= b_mag;
                            q_neg <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            r_neg <= bus.is_signed & bus.dividend[WIDTH-1];
                            state <= CALC;
                        end
                    end else begin
                        if (bus.mthi_we) hi_q <= bus.wdata;
                        if (bus.mtlo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    work  <= work_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    lo_q   <= q_neg ? -work[WIDTH-1:0] : work[WIDTH-1:0];
                    hi_q   <= r_neg ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_hilo_div_seq.sv
// Bench for hilo_div_seq: directed cases plus random divides against an arithmetic reference.
module tb_hilo_div_seq;
    logic clock;
    logic reset;
    int   checks;
    int   passes;

    hilo_div_seq_if #(.WIDTH(32)) bus ();

    hilo_div_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MIPS DIV/DIVU semantics from plain 64-bit arithmetic (truncating division).
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Drives one divide and measures it; comparisons are made by the callers.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit mthi, input bit mtlo, input logic [31:0] wd, input bit disturb,
                           output int cycles, output bit done_ok, output bit held,
                           output logic [31:0] rh, output logic [31:0] rl, output logic dz);
        logic [31:0] h0, l0;
        int n;
        @(negedge clock);
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.mthi_we   = mthi;
        bus.mtlo_we   = mtlo;
        bus.wdata     = wd;
        @(negedge clock);
        bus.start   = 1'b0;
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        n = 0;
        held = 1'b1;
        done_ok = 1'b1;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
            if (bus.done !== 1'b0) done_ok = 1'b0;
            if (disturb && n == 5) begin
                bus.start    = 1'b1;
                bus.dividend = ~a;
                bus.divisor  = 32'd3;
                bus.mthi_we  = 1'b1;
                bus.wdata    = 32'h1234_5678;
            end else begin
                bus.start   = 1'b0;
                bus.mthi_we = 1'b0;
            end
            @(negedge clock);
        end
        bus.start   = 1'b0;
        bus.mthi_we = 1'b0;
        cycles = n;
        if (bus.done !== 1'b1) done_ok = 1'b0;
        rh = bus.hi;
        rl = bus.lo;
        dz = bus.div_zero;
        @(negedge clock);
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.mthi_we   = 1'b0;
        bus.mtlo_we   = 1'b0;
        bus.wdata     = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end else passes++;
        reset = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        run_div(1'b0, 32'd7, 32'd2, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (c !== 33) $display("FAIL u7_2_busy_cycles: got %0d, required 33", c); else passes++;
        checks++;
        if (l !== 32'd3 || h !== 32'd1) $display("FAIL u7_2_result: lo=%h hi=%h, required lo=3 hi=1", l, h);
        else passes++;
        checks++;
        if (dk !== 1'b1 || hd !== 1'b1 || z !== 1'b0)
            $display("FAIL u7_2_done_hold_dz: done_ok=%b held=%b dz=%b, required 1 1 0", dk, hd, z);
        else passes++;
    endtask

    task automatic test_signed();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF)
            $display("FAIL s_m7_2: lo=%h hi=%h, required lo=fffffffd hi=ffffffff", l, h);
        else passes++;
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'hFFFF_FFFD || h !== 32'd1)
            $display("FAIL s_7_m2: lo=%h hi=%h, required lo=fffffffd hi=00000001", l, h);
        else passes++;
    endtask

    task automatic test_overflow();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'h8000_0000 || h !== 32'd0 || c !== 33)
            $display("FAIL s_overflow: lo=%h hi=%h cyc=%0d, required lo=80000000 hi=0 cyc=33", l, h, c);
        else passes++;
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'd0 || h !== 32'h8000_0000)
            $display("FAIL u_big_divisor: lo=%h hi=%h, required lo=0 hi=80000000", l, h);
        else passes++;
    endtask

    task automatic test_div_zero();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        run_div(1'b0, 32'h1234_5678, 32'd0, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (c !== 1) $display("FAIL dz_busy_cycles: got %0d, required 1", c); else passes++;
        checks++;
        if (l !== 32'hFFFF_FFFF || h !== 32'h1234_5678 || z !== 1'b1 || dk !== 1'b1)
            $display("FAIL dz_result: lo=%h hi=%h dz=%b done_ok=%b, required ffffffff 12345678 1 1",
                     l, h, z, dk);
        else passes++;
        run_div(1'b0, 32'd10, 32'd3, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'd3 || h !== 32'd1 || z !== 1'b0)
            $display("FAIL dz_cleared: lo=%h hi=%h dz=%b, required lo=3 hi=1 dz=0", l, h, z);
        else passes++;
    endtask

    task automatic test_mt();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        logic [31:0] lo_before;
        @(negedge clock);
        bus.mthi_we = 1'b1;
        bus.wdata   = 32'hAAAA_5555;
        @(negedge clock);
        bus.mthi_we = 1'b0;
        checks++;
        if (bus.hi !== 32'hAAAA_5555 || bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL mthi_write: hi=%h done=%b busy=%b, required aaaa5555 0 0",
                     bus.hi, bus.done, bus.busy);
        else passes++;
        lo_before = bus.lo;
        run_div(1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_DEAD, 1'b1, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'd14 || h !== 32'd2 || c !== 33)
            $display("FAIL start_beats_mt: lo=%h hi=%h cyc=%0d, required lo=e hi=2 cyc=33", l, h, c);
        else passes++;
        checks++;
        if (hd !== 1'b1 || dk !== 1'b1 || lo_before === 32'h0000_DEAD)
            $display("FAIL busy_ignores_mt_start: held=%b done_ok=%b, required 1 1", hd, dk);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        bit seen;
        @(negedge clock);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_mid_divide: hi=%h lo=%h busy=%b done=%b, required all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        else passes++;
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'd0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL no_done_after_reset: activity=%b, required 0", seen);
        else passes++;
        run_div(1'b0, 32'd9, 32'd4, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
        checks++;
        if (l !== 32'd2 || h !== 32'd1 || c !== 33)
            $display("FAIL after_reset_9_4: lo=%h hi=%h cyc=%0d, required lo=2 hi=1 cyc=33", l, h, c);
        else passes++;
    endtask

    task automatic test_random();
        int c; bit dk, hd; logic [31:0] h, l; logic z;
        logic [31:0] a, b, eq, er;
        bit sgn;
        int exp_cyc;
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 9));
                1:       b = (i % 6 == 0) ? 32'd0 : $urandom;
                2:       b = -32'($urandom_range(1, 9));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(sgn, a, b, eq, er);
            exp_cyc = (b == 32'd0) ? 1 : 33;
            run_div(sgn, a, b, 1'b0, 1'b0, '0, 1'b0, c, dk, hd, h, l, z);
            checks++;
            if (l !== eq || h !== er || c !== exp_cyc || z !== (b == 32'd0) || dk !== 1'b1 || hd !== 1'b1)
                $display("FAIL random_%0d: s=%b %h/%h got lo=%h hi=%h cyc=%0d dz=%b done_ok=%b held=%b, required lo=%h hi=%h cyc=%0d",
                         i, sgn, a, b, l, h, c, z, dk, hd, eq, er, exp_cyc);
            else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_mt();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
